// File: rtl/uart_pkg.sv
// UART shared definitions: tx state encoding, parity modes
// and the bit-period counter limit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Terminal count of the baud counter; one bit is this plus one clocks.
  function automatic int calc_bit_cnt(input int clk_freq,
                                      input int baud);
    return clk_freq / baud - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_end_o on the last clock of each bit.
// Dropping en_i parks the counter at zero.
module uart_baud_tick #(
  parameter int BIT_CNT = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int W = $clog2(BIT_CNT + 1);
  localparam logic [W-1:0] MAX = W'(BIT_CNT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: wrap at the terminal value, clear when disabled.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (!en_i || cnt_q == MAX) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && (cnt_q == MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity,
// one or two stop bits, with a valid/ready source handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (BIT_CNT < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  tx_state_e            state_q;
  logic                 tx_q;
  logic                 done_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic [3:0]           idx_q;
  logic                 stop_q;
  logic                 bit_end;
  logic                 tick_en;

  assign tick_en = (state_q != ST_IDLE);

  uart_baud_tick #(
    .BIT_CNT (BIT_CNT)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (tick_en),
    .bit_end_o (bit_end)
  );

  // Frame sequencer with registered line and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          idx_q  <= '0;
          stop_q <= 1'b0;
          if (tx_valid) begin
            sh_q    <= tx_data;
            par_q   <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_IDX) begin
              if (PARITY != PAR_NONE) begin
                tx_q    <= par_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              stop_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity,
// even, odd and two stop bits at 10 clocks per bit.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n;

  logic v0, v1, v2, v3;
  logic [7:0] d0, d1, d2, d3;
  logic t0, t1, t2, t3;
  logic r0, r1, r2, r3;
  logic b0, b1, b2, b3;
  logic n0, n1, n2, n3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .tx(t0), .tx_busy(b0), .tx_done(n0));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx(t1), .tx_busy(b1), .tx_done(n1));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .tx(t2), .tx_busy(b2), .tx_done(n2));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(v3),
    .tx_ready(r3), .tx(t3), .tx_busy(b3), .tx_done(n3));

  function automatic logic get_tx(input int i);
    case (i)
      0: return t0;
      1: return t1;
      2: return t2;
      default: return t3;
    endcase
  endfunction

  function automatic logic get_done(input int i);
    case (i)
      0: return n0;
      1: return n1;
      2: return n2;
      default: return n3;
    endcase
  endfunction

  function automatic logic get_ready(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      default: return r3;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0: return b0;
      1: return b1;
      2: return b2;
      default: return b3;
    endcase
  endfunction

  task automatic set_in(input int i, input logic v, input logic [7:0] d);
    case (i)
      0: begin v0 = v; d0 = d; end
      1: begin v1 = v; d1 = d; end
      2: begin v2 = v; d2 = d; end
      default: begin v3 = v; d3 = d; end
    endcase
  endtask

  // Expected line level per bit period for instance i.
  task automatic build(input int i, input logic [7:0] d,
                       output logic [11:0] pat, output int n);
    pat = '1;
    pat[0] = 1'b0;
    for (int k = 0; k < 8; k++) pat[k+1] = d[k];
    n = 9;
    if (i == 1) begin pat[9] = ^d;  n = 10; end
    if (i == 2) begin pat[9] = ~^d; n = 10; end
    pat[n] = 1'b1;
    n = n + 1;
    if (i == 3) begin pat[n] = 1'b1; n = n + 1; end
  endtask

  task automatic run_frame(input int i, input logic [7:0] d,
                           input bit toggle, input string nm);
    logic [11:0] pat;
    int n;
    int bad;
    int early;
    int nbusy;
    build(i, d, pat, n);
    @(negedge clk);
    checks++;
    if (get_ready(i) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", nm, get_ready(i));
    end
    set_in(i, 1'b1, d);
    @(negedge clk);
    set_in(i, 1'b0, d);
    early = 0;
    nbusy = 0;
    for (int b = 0; b < n; b++) begin
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (get_tx(i) !== pat[b]) bad++;
        if (get_done(i) !== 1'b0) early++;
        if (get_busy(i) !== 1'b1) nbusy++;
        if (toggle && c == 3)
          set_in(i, (b < n - 1) && (b % 2 == 0), d ^ 8'(b + 1));
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: tx wrong in %0d cycles, want %b",
                 nm, b, bad, pat[b]);
      end
    end
    set_in(i, 1'b0, d);
    checks++;
    if (early != 0 || nbusy != 0) begin
      errors++;
      $display("FAIL %s in_frame: early_done=%0d not_busy=%0d want 0/0",
               nm, early, nbusy);
    end
    checks++;
    if (get_done(i) !== 1'b1 || get_ready(i) !== 1'b1 ||
        get_tx(i) !== 1'b1) begin
      errors++;
      $display("FAIL %s end: done=%b ready=%b tx=%b want 1/1/1",
               nm, get_done(i), get_ready(i), get_tx(i));
    end
    @(negedge clk);
    checks++;
    if (get_done(i) !== 1'b0 || get_busy(i) !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b want 0/0",
               nm, get_done(i), get_busy(i));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    set_in(3, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_tx(i) !== 1'b1 || get_ready(i) !== 1'b1 ||
          get_busy(i) !== 1'b0 || get_done(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset%0d: tx=%b rdy=%b busy=%b done=%b want 1100",
                 i, get_tx(i), get_ready(i), get_busy(i), get_done(i));
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] pa;
    logic [11:0] pb;
    int n;
    int bad;
    int pulses;
    logic want;
    build(0, 8'h00, pa, n);
    build(0, 8'hFF, pb, n);
    @(negedge clk);
    set_in(0, 1'b1, 8'h00);
    @(negedge clk);
    set_in(0, 1'b1, 8'hFF);
    bad = 0;
    pulses = 0;
    for (int cy = 0; cy < 210; cy++) begin
      if (cy < 100) want = pa[cy / 10];
      else if (cy == 100) want = 1'b1;
      else if (cy < 201) want = pb[(cy - 101) / 10];
      else want = 1'b1;
      if (t0 !== want) bad++;
      if (n0 === 1'b1) pulses++;
      if (cy == 100 || cy == 201) begin
        checks++;
        if (n0 !== 1'b1 || r0 !== 1'b1) begin
          errors++;
          $display("FAIL b2b done@%0d: done=%b ready=%b want 1/1",
                   cy, n0, r0);
        end
      end
      if (cy == 101) set_in(0, 1'b0, 8'hFF);
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b tx: %0d wrong cycles want 0", bad);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    int pulses;
    @(negedge clk);
    set_in(0, 1'b1, 8'hA5);
    @(negedge clk);
    set_in(0, 1'b0, 8'hA5);
    repeat (44) @(negedge clk);
    checks++;
    if (t0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid pre: tx=%b want 0", t0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (t0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b1 || n0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: tx=%b busy=%b rdy=%b done=%b want 1010",
               t0, b0, r0, n0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    pulses = 0;
    for (int cy = 0; cy < 120; cy++) begin
      if (t0 !== 1'b1) bad++;
      if (n0 !== 1'b0) pulses++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || pulses != 0) begin
      errors++;
      $display("FAIL rst_mid after: low=%0d done=%0d want 0/0", bad, pulses);
    end
  endtask

  initial begin
    test_reset();
    run_frame(0, 8'hA5, 1'b0, "a5");
    test_back_to_back();
    run_frame(1, 8'h07, 1'b0, "even07");
    run_frame(2, 8'h07, 1'b0, "odd07");
    run_frame(3, 8'h55, 1'b1, "stop2_55");
    test_reset_midframe();
    run_frame(0, 8'h3C, 1'b0, "post_rst_3c");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: serial bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8: payload bits per frame, legal range 5..9.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-006 clk  input  1: system clock; all logic is on the rising edge.
REQ-007 rst_n  input  1: reset, asynchronous, active-low.
REQ-008 tx_data  input  DATA_BITS: byte to send, sampled only on acceptance.
REQ-009 tx_valid  input  1: tx_data is valid; held by the source until accepted.
REQ-010 tx_ready  output  1: block can accept a frame; high only in IDLE.
REQ-011 tx  output  1: serial line, registered, idle high.
REQ-012 tx_busy  output  1: a frame is in progress; high in every non-IDLE state.
REQ-013 tx_done  output  1: one-cycle pulse after the last stop bit completes.

Function
REQ-014 BIT_CNT SHALL be CLK_FREQ/BAUD_RATE - 1 using integer division; each bit on tx SHALL last exactly BIT_CNT+1 clk cycles.
REQ-015 The baud counter SHALL be $clog2(BIT_CNT+1) bits wide; it SHALL be held at 0 in IDLE and restart at 0 on every state change.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-017 Acceptance SHALL occur on a rising edge where tx_valid and tx_ready are both 1; on that edge tx_data is latched into a shift register and the state goes to START.
REQ-018 In START, tx SHALL be 0; the first tx low cycle SHALL be the cycle immediately after the acceptance edge.
REQ-019 DATA SHALL send DATA_BITS bits LSB first, shifting right one bit per bit period; the bit index SHALL run from 0 to DATA_BITS-1.
REQ-020 PARITY SHALL be entered only when PARITY != 0; the sent bit SHALL be XOR of the latched data for even parity and its inverse for odd parity.
REQ-021 STOP SHALL drive tx = 1 for STOP_BITS bit periods, then return to IDLE.
REQ-022 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP; tx_ready SHALL be 1 in that same cycle.
REQ-023 A tx_valid already high in that first IDLE cycle SHALL be accepted there, giving zero extra idle bit time between frames (one clk of idle).
REQ-024 tx_valid and tx_data SHALL be ignored while tx_busy = 1; changing tx_data mid-frame SHALL NOT alter the frame on tx.
REQ-025 An illegal state encoding SHALL return to IDLE with tx = 1.
REQ-026 Elaboration SHALL fail if BIT_CNT < 1, DATA_BITS is outside 5..9, PARITY > 2 or STOP_BITS is not 1 or 2.

Reset
REQ-027 While rst_n = 0: state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, all counters and the shift register = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame at once, driving tx high asynchronously; no tx_done SHALL follow.

Structure
REQ-029 Package uart_pkg SHALL hold the tx state enum, the parity-mode constants (NONE/ODD/EVEN) and the BIT_CNT computation function, shared with the receive path.
REQ-030 One sub-module, uart_baud_tick, SHALL produce a one-cycle bit_end pulse when the counter reaches BIT_CNT, with an enable input that clears the counter when low.

Verification
REQ-031 Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit), DATA_BITS=8, PARITY=0, STOP_BITS=1.
REQ-032 Send 0xA5 -> tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, high 10 cycles; tx_done 100 cycles after the first tx low cycle; frame 101 cycles from acceptance to tx_done.
REQ-033 Hold tx_valid high with 0x00 then 0xFF -> second start bit begins 1 cycle after the first tx_done; exactly 2 tx_done pulses.
REQ-034 PARITY=2 with 0x07, then PARITY=1 with 0x07 -> parity bit 1 for even, 0 for odd; frame lasts 110 cycles.
REQ-035 STOP_BITS=2 with 0x55 -> tx high 20 cycles before tx_done; toggling tx_data and tx_valid mid-frame leaves the bit pattern unchanged.
REQ-036 rst_n pulsed low during DATA bit 3 -> tx = 1 immediately, no tx_done; the next 0x3C frame after release is correct.
